// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one synchronous memory port with saturating wait counters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the data bus has fixed priority.
module mem_arbiter #(
    parameter int STAT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // instruction-fetch master
    input  logic [29:0]       i_inst_addr,
    input  logic [31:0]       i_inst_data_d,
    output logic [31:0]       o_inst_data_q,
    input  logic              i_inst_read,
    input  logic              i_inst_write,
    output logic              o_inst_ready,
    input  logic [3:0]        i_inst_byte_sel,
    // load/store master
    input  logic [29:0]       i_data_addr,
    input  logic [31:0]       i_data_data_d,
    output logic [31:0]       o_data_data_q,
    input  logic              i_data_read,
    input  logic              i_data_write,
    output logic              o_data_ready,
    input  logic [3:0]        i_data_byte_sel,
    // shared memory port
    output logic [29:0]       o_mem_addr,
    output logic [31:0]       o_mem_data_d,
    input  logic [31:0]       i_mem_data_q,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic              i_mem_ready,
    output logic [3:0]        o_mem_byte_sel,
    // status
    output logic              o_grant_inst,
    output logic              o_grant_data,
    output logic [STAT_W-1:0] o_inst_wait,
    output logic [STAT_W-1:0] o_data_wait
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    state_t            r_state;
    logic [STAT_W-1:0] r_inst_wait;
    logic [STAT_W-1:0] r_data_wait;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              r_last_inst;
`endif

    logic w_inst_req;
    logic w_data_req;
    logic w_pick_inst;
    logic w_pick_data;
    logic w_grant_inst;
    logic w_grant_data;

    assign w_inst_req = i_inst_read | i_inst_write;
    assign w_data_req = i_data_read | i_data_write;

    // Owner selection: combinational arbitration in IDLE, locked owner while busy.
    always_comb begin
        w_pick_inst = 1'b0;
        w_pick_data = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inst_req && w_data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (r_last_inst) begin
                        w_pick_data = 1'b1;
                    end else begin
                        w_pick_inst = 1'b1;
                    end
`else
                    w_pick_data = 1'b1;
`endif
                end else if (w_inst_req) begin
                    w_pick_inst = 1'b1;
                end else if (w_data_req) begin
                    w_pick_data = 1'b1;
                end else begin
                    w_pick_inst = 1'b0;
                    w_pick_data = 1'b0;
                end
            end
            ST_BUSY_I: w_pick_inst = 1'b1;
            ST_BUSY_D: w_pick_data = 1'b1;
            default: begin
                w_pick_inst = 1'b0;
                w_pick_data = 1'b0;
            end
        endcase
    end

    // Gating with reset kills the memory strobes and master readies asynchronously.
    assign w_grant_inst = w_pick_inst & i_rst_n;
    assign w_grant_data = w_pick_data & i_rst_n;

    // Route the owner's request to memory and the memory response back to the owner only.
    always_comb begin
        o_mem_addr     = 30'h0;
        o_mem_data_d   = 32'h0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_mem_byte_sel = 4'b0000;
        if (w_grant_inst) begin
            o_mem_addr     = i_inst_addr;
            o_mem_data_d   = i_inst_data_d;
            o_mem_read     = i_inst_read;
            o_mem_write    = i_inst_write;
            o_mem_byte_sel = i_inst_byte_sel;
        end else if (w_grant_data) begin
            o_mem_addr     = i_data_addr;
            o_mem_data_d   = i_data_data_d;
            o_mem_read     = i_data_read;
            o_mem_write    = i_data_write;
            o_mem_byte_sel = i_data_byte_sel;
        end else begin
            o_mem_read     = 1'b0;
            o_mem_write    = 1'b0;
        end
    end

    assign o_inst_ready  = w_grant_inst & i_mem_ready;
    assign o_data_ready  = w_grant_data & i_mem_ready;
    assign o_inst_data_q = w_grant_inst ? i_mem_data_q : 32'h0;
    assign o_data_data_q = w_grant_data ? i_mem_data_q : 32'h0;
    assign o_grant_inst  = w_grant_inst;
    assign o_grant_data  = w_grant_data;
    assign o_inst_wait   = r_inst_wait;
    assign o_data_wait   = r_data_wait;

    // Transaction FSM and last-served pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_inst <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_inst && !i_mem_ready) begin
                        r_state <= ST_BUSY_I;
                    end else if (w_grant_data && !i_mem_ready) begin
                        r_state <= ST_BUSY_D;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (i_mem_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if ((w_grant_inst || w_grant_data) && i_mem_ready) begin
                r_last_inst <= w_grant_inst;
            end else begin
                r_last_inst <= r_last_inst;
            end
`endif
        end
    end

    // Saturating wait-cycle counters, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst_wait <= {STAT_W{1'b0}};
            r_data_wait <= {STAT_W{1'b0}};
        end else begin
            if (w_inst_req && !w_grant_inst && (r_inst_wait != STAT_MAX)) begin
                r_inst_wait <= r_inst_wait + STAT_ONE;
            end else begin
                r_inst_wait <= r_inst_wait;
            end
            if (w_data_req && !w_grant_data && (r_data_wait != STAT_MAX)) begin
                r_data_wait <= r_data_wait + STAT_ONE;
            end else begin
                r_data_wait <= r_data_wait;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int STAT_W = 4;
    localparam int SAT    = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] inst_addr, data_addr, mem_addr;
    logic [31:0] inst_dd, data_dd, inst_dq, data_dq, mem_dd, mem_dq;
    logic        inst_read, inst_write, inst_ready;
    logic        data_read, data_write, data_ready;
    logic [3:0]  inst_bs, data_bs, mem_bs;
    logic        mem_read, mem_write, mem_ready;
    logic        grant_inst, grant_data;
    logic [STAT_W-1:0] inst_wait, data_wait;

    always #5 clk = ~clk;

    mem_arbiter #(.STAT_W(STAT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_inst_addr(inst_addr), .i_inst_data_d(inst_dd), .o_inst_data_q(inst_dq),
        .i_inst_read(inst_read), .i_inst_write(inst_write), .o_inst_ready(inst_ready),
        .i_inst_byte_sel(inst_bs),
        .i_data_addr(data_addr), .i_data_data_d(data_dd), .o_data_data_q(data_dq),
        .i_data_read(data_read), .i_data_write(data_write), .o_data_ready(data_ready),
        .i_data_byte_sel(data_bs),
        .o_mem_addr(mem_addr), .o_mem_data_d(mem_dd), .i_mem_data_q(mem_dq),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .i_mem_ready(mem_ready),
        .o_mem_byte_sel(mem_bs),
        .o_grant_inst(grant_inst), .o_grant_data(grant_data),
        .o_inst_wait(inst_wait), .o_data_wait(data_wait)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // transaction-level model: who holds memory (0 none, 1 inst, 2 data), last served, wait counts
    int m_owner;
    bit m_last_inst;
    int m_iw, m_dw;

    bit seen_ri, seen_rd;
    int gi_cycles;
    logic cap_gi, cap_gd, cap_ir, cap_dr, cap_mw;
    logic [31:0] cap_idq;
    logic [3:0]  cap_mbs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = 0;
        m_last_inst = 1'b1;
        m_iw        = 0;
        m_dw        = 0;
    endtask

    // One clock cycle: compare all outputs against the model, then advance the model at the edge.
    task automatic step();
        int win;
        bit ri, rd;
        logic exp_rd, exp_wr;
        logic [3:0] exp_bs;
        #1;
        ri = inst_read | inst_write;
        rd = data_read | data_write;
        if (!rst_n) model_reset();
        win = 0;
        if (rst_n) begin
            if (m_owner != 0) win = m_owner;
            else if (ri && rd) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = m_last_inst ? 2 : 1;
`else
                win = 2;
`endif
            end
            else if (ri) win = 1;
            else if (rd) win = 2;
        end
        exp_rd = (win == 1) ? inst_read  : (win == 2) ? data_read  : 1'b0;
        exp_wr = (win == 1) ? inst_write : (win == 2) ? data_write : 1'b0;
        exp_bs = (win == 1) ? inst_bs    : (win == 2) ? data_bs    : 4'b0000;
        check("grant_inst", {31'h0, grant_inst}, {31'h0, win == 1});
        check("grant_data", {31'h0, grant_data}, {31'h0, win == 2});
        check("mem_read",   {31'h0, mem_read},   {31'h0, exp_rd});
        check("mem_write",  {31'h0, mem_write},  {31'h0, exp_wr});
        check("mem_bytesel", {28'h0, mem_bs},    {28'h0, exp_bs});
        if (win != 0) begin
            check("mem_addr", {2'b00, mem_addr}, {2'b00, (win == 1) ? inst_addr : data_addr});
            check("mem_dataD", mem_dd, (win == 1) ? inst_dd : data_dd);
        end
        check("inst_ready", {31'h0, inst_ready}, {31'h0, (win == 1) && mem_ready});
        check("data_ready", {31'h0, data_ready}, {31'h0, (win == 2) && mem_ready});
        check("inst_dataQ", inst_dq, (win == 1) ? mem_dq : 32'h0);
        check("data_dataQ", data_dq, (win == 2) ? mem_dq : 32'h0);
        check("inst_wait", 32'(inst_wait), 32'(m_iw));
        check("data_wait", 32'(data_wait), 32'(m_dw));
        seen_ri = (win == 1) && mem_ready;
        seen_rd = (win == 2) && mem_ready;
        if (grant_inst) gi_cycles++;
        cap_gi = grant_inst; cap_gd = grant_data; cap_ir = inst_ready; cap_dr = data_ready;
        cap_idq = inst_dq; cap_mw = mem_write; cap_mbs = mem_bs;
        @(posedge clk);
        if (rst_n) begin
            if (ri && win != 1 && m_iw < SAT) m_iw++;
            if (rd && win != 2 && m_dw < SAT) m_dw++;
            if (win != 0 && mem_ready) begin
                m_owner     = 0;
                m_last_inst = (win == 1);
            end else if (win != 0) begin
                m_owner = win;
            end
        end
        @(negedge clk);
    endtask

    task automatic new_req(output logic rd, output logic wr, output logic [29:0] a,
                           output logic [31:0] d, output logic [3:0] bs);
        int kind;
        kind = $urandom_range(15, 0);
        rd = (kind < 8) || (kind == 15);
        wr = (kind >= 8);
        a  = 30'($urandom);
        d  = $urandom;
        bs = 4'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        inst_addr = 30'h0; inst_dd = 32'h0; inst_read = 1'b0; inst_write = 1'b0; inst_bs = 4'h0;
        data_addr = 30'h0; data_dd = 32'h0; data_read = 1'b0; data_write = 1'b0; data_bs = 4'h0;
        mem_dq = 32'h0; mem_ready = 1'b0;
        model_reset();
        @(negedge clk);
        step(); step();
        check("rst_grants", {30'h0, cap_gi, cap_gd}, 32'h0);
        check("rst_waits", 32'({inst_wait, data_wait}), 32'h0);
        rst_n = 1'b1;

        // instruction read, memory ready on the third cycle
        gi_cycles = 0;
        inst_read = 1'b1; inst_addr = 30'h1234; inst_bs = 4'hF;
        step(); step();
        mem_ready = 1'b1; mem_dq = 32'hDEADBEEF;
        step();
        check("t1_inst_ready", {31'h0, cap_ir}, 32'h1);
        check("t1_inst_dataQ", cap_idq, 32'hDEADBEEF);
        inst_read = 1'b0; mem_ready = 1'b0;
        step();
        check("t1_grant_cycles", 32'(gi_cycles), 32'd3);
        check("t1_inst_wait", 32'(inst_wait), 32'd0);

        // simultaneous requests, 2-cycle memory: data first, instruction right after
        inst_read = 1'b1; inst_addr = 30'h2000;
        data_write = 1'b1; data_addr = 30'h3000; data_dd = 32'h55AA; data_bs = 4'hF;
        step();
        check("t2_data_first", {31'h0, cap_gd}, 32'h1);
        mem_ready = 1'b1;
        step();
        data_write = 1'b0; mem_ready = 1'b0;
        step();
        check("t2_inst_no_bubble", {31'h0, cap_gi}, 32'h1);
        mem_ready = 1'b1;
        step();
        inst_read = 1'b0; mem_ready = 1'b0;
        check("t2_inst_wait", 32'(inst_wait), 32'd2);
        check("t2_data_wait", 32'(data_wait), 32'd0);

        // zero-wait data write, then instruction granted at once
        data_write = 1'b1; data_addr = 30'h100; data_bs = 4'b0011; mem_ready = 1'b1;
        step();
        check("t3_mem_write", {31'h0, cap_mw}, 32'h1);
        check("t3_bytesel", {28'h0, cap_mbs}, 32'h3);
        check("t3_data_ready", {31'h0, cap_dr}, 32'h1);
        data_write = 1'b0; inst_read = 1'b1; inst_addr = 30'h4000; mem_ready = 1'b0;
        step();
        check("t3_inst_granted", {31'h0, cap_gi}, 32'h1);

        // instruction drops its request while busy; grant stays until memory ready
        inst_read = 1'b0; data_read = 1'b1; data_addr = 30'h5000;
        step();
        check("t4_grant_held", {30'h0, cap_gi, cap_gd}, 32'h2);
        mem_ready = 1'b1;
        step();
        check("t4_ready_to_inst", {31'h0, cap_ir}, 32'h1);
        mem_ready = 1'b0;
        step();
        check("t4_data_next", {31'h0, cap_gd}, 32'h1);
        mem_ready = 1'b1;
        step();
        data_read = 1'b0; mem_ready = 1'b0;

        // saturation of the data wait counter behind a long instruction access
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; inst_read = 1'b1;
        step();
        data_read = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t5_data_wait_sat", 32'(data_wait), 32'd15);
        mem_ready = 1'b1;
        step();
        inst_read = 1'b0; mem_ready = 1'b0;
        step();
        check("t5_busy_d", {31'h0, cap_gd}, 32'h1);

        // reset in the middle of a data transaction
        rst_n = 1'b0;
        #1;
        check("t6_rst_mem_read", {31'h0, mem_read}, 32'h0);
        check("t6_rst_data_ready", {31'h0, data_ready}, 32'h0);
        step();
        rst_n = 1'b1; data_read = 1'b0; mem_ready = 1'b1;
        step();
        check("t6_no_spurious_ready", {30'h0, cap_ir, cap_dr}, 32'h0);
        check("t6_waits_clear", 32'({inst_wait, data_wait}), 32'h0);
        mem_ready = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (seen_ri) begin inst_read = 1'b0; inst_write = 1'b0; end
            if (seen_rd) begin data_read = 1'b0; data_write = 1'b0; end
            if ((inst_read | inst_write) && $urandom_range(24, 0) == 0) begin
                inst_read = 1'b0; inst_write = 1'b0;
            end else if (!(inst_read | inst_write) && $urandom_range(2, 0) == 0) begin
                new_req(inst_read, inst_write, inst_addr, inst_dd, inst_bs);
            end
            if ((data_read | data_write) && $urandom_range(24, 0) == 0) begin
                data_read = 1'b0; data_write = 1'b0;
            end else if (!(data_read | data_write) && $urandom_range(2, 0) == 0) begin
                new_req(data_read, data_write, data_addr, data_dd, data_bs);
            end
            mem_ready = ($urandom_range(2, 0) == 0);
            mem_dq    = $urandom;
            rst_n     = ($urandom_range(299, 0) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that lets the instruction-fetch bus and the load/store data bus share one unified memory port. It sits between the fetch and memory stages on one side and the external synchronous memory on the other. It grants one outstanding transaction at a time, routes `ready`/`dataQ` back only to the granted master, and keeps saturating wait-cycle counters for performance analysis.

## Interface
- `STAT_W`, default 16: width of each wait-cycle counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instBus` memory_bus.slave: fetch-side request bus. Fields: `addr` 30 bits, `dataD` 32, `dataQ` 32, `read`, `write`, `ready`, `byteSel` 4.
- `dataBus` memory_bus.slave: load/store-side request bus, same fields.
- `memBus` memory_bus.master: the shared memory port.
- `grantInst_o` out 1: the instruction bus owns `memBus` this cycle.
- `grantData_o` out 1: the data bus owns `memBus` this cycle.
- `instWait_o` out STAT_W: saturating count of cycles the instruction bus requested but was not granted.
- `dataWait_o` out STAT_W: the same count for the data bus.

## Operation
- A master's request is `read | write`. The master holds `addr`, `dataD`, `byteSel`, `read` and `write` stable until it sees `ready`=1.
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY_I: the instruction bus owns `memBus`.
  - BUSY_D: the data bus owns `memBus`.
- Arbitration happens combinationally in IDLE:
  - Only one master requests: it wins.
  - Both request: winner is set by the policy in Configuration.
  - The winner's signals drive `memBus` in the same cycle.
- Transitions out of IDLE:
  - Request granted and `memBus.ready`=0: go to BUSY_I or BUSY_D.
  - Request granted and `memBus.ready`=1 (zero-wait memory): the transaction completes in that cycle and the FSM stays in IDLE.
- In BUSY_x, the grant is locked to x and x's signals are forwarded unchanged. On `memBus.ready`=1, `ready` and `dataQ` go to x and the FSM returns to IDLE.
- A master that drops its request while in BUSY does not release the grant. The grant is held until `memBus.ready`, because the memory has already accepted the request. The resulting `ready` is still routed to that master.
- Non-granted master:
  - Its `ready` is 0.
  - Its `dataQ` is 32'h0.
- No grant:
  - `memBus.read` and `memBus.write` are 0.
  - `memBus.addr` and `memBus.dataD` are don't-care.
  - `memBus.byteSel` is 4'b0000.
- `read` and `write` asserted together by one master is illegal. The arbiter forwards both unchanged and checks nothing.
- Wait counters:
  - Each cycle a master requests without being the granted master, its counter increments.
  - Counters saturate at 2^STAT_W−1 and never wrap.
  - They are cleared only by reset.

## Timing
- Arbitration latency is 0 cycles: a request seen in IDLE reaches `memBus` in the same cycle.
- Back-to-back: if `ready` arrives in cycle N, the next transaction (either master) can start in cycle N+1 with no bubble.
- Reset values:
  - State IDLE.
  - `grantInst_o` = `grantData_o` = 0.
  - Both counters 0.
  - Round-robin pointer = "instruction last served".
- While `rst`=0:
  - `memBus.read` and `memBus.write` are forced to 0.
  - Both master `ready` outputs are forced to 0.
- Reset asserted mid-transaction aborts the transaction immediately. The memory's late `ready` after reset release, if any, is ignored while in IDLE with no request.
- At most one of `grantInst_o` and `grantData_o` is 1 in any cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request in IDLE, the master not served most recently wins.
  - A 1-bit last-served pointer updates on every completed transaction.
- Not defined:
  - Fixed priority: the data bus always wins a simultaneous request. This avoids memory-stage deadlock behind fetch.
  - The pointer logic is removed.

## Test plan
- Instruction read only, memory `ready` after 3 cycles:
  - `grantInst_o`=1 for 3 cycles, `memBus.addr` = `instBus.addr`.
  - `instBus.ready`=1 with `dataQ`=32'hDEADBEEF in cycle 3.
  - `instWait_o`=0.
- Both masters request in the same cycle, 2-cycle memory:
  - Fixed priority: data is served first, then instruction with no idle cycle between them; `instWait_o`=2.
  - Round-robin after reset: data is served first (pointer = instruction), then instruction.
- Zero-wait memory (`ready` in the request cycle), data write to 30'h100 with `byteSel`=4'b0011:
  - The write completes in 1 cycle and the FSM stays in IDLE.
  - An instruction request in the next cycle is granted immediately.
- Instruction master drops `read` in the middle of BUSY_I while the data bus requests:
  - The grant stays with instruction until `memBus.ready`.
  - Data is granted the following cycle.
- Reset pulse in the middle of BUSY_D:
  - `memBus.read`/`write` drop to 0 asynchronously.
  - After release: IDLE, both counters 0, no spurious master `ready`.
- Data bus continuously requests with instruction held in BUSY, `STAT_W`=4:
  - `dataWait_o` saturates at 15 and stays at 15.
